// File: rtl/cache_ctrl.sv
// cache_ctrl -- miss-handling controller for a direct-mapped, write-back data
// cache (64 lines x 4 words of 16 bits, 5-bit tag, 6-bit index).
//
// Hits are served combinationally with no added stall. A miss latches the
// resident (victim) line, writes it back if dirty (WB), fetches the requested
// line (FILL), and then writes it into the cache for one cycle (UPD). The core
// holds its request throughout, and the request then hits on the next lookup.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_addr/re/we/wdata     core load/store request (held while cpu_stall)
//   cpu_rdata, cpu_stall     load data / request-not-done
//   c_addr, c_re, c_we,      cache array control: line address, read/write
//   c_wr_data, c_wdirty        enables, line and dirty bit to write
//   c_hit, c_dirty,          cache array lookup result for c_addr
//   c_rd_data, c_tag_out
//   m_addr, m_re, m_we,      memory line port (registered, glitch-free)
//   m_wdata, m_rdata, m_rdy
//   hit_cnt, miss_cnt        saturating performance counters
module cache_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [12:0]      cpu_addr,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic [15:0]      cpu_wdata,
  output logic [15:0]      cpu_rdata,
  output logic             cpu_stall,
  output logic [10:0]      c_addr,
  output logic [63:0]      c_wr_data,
  output logic             c_wdirty,
  output logic             c_we,
  output logic             c_re,
  input  logic             c_hit,
  input  logic             c_dirty,
  input  logic [63:0]      c_rd_data,
  input  logic [4:0]       c_tag_out,
  output logic [10:0]      m_addr,
  output logic             m_re,
  output logic             m_we,
  output logic [63:0]      m_wdata,
  input  logic [63:0]      m_rdata,
  input  logic             m_rdy,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {IDLE, WB, FILL, UPD} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic [63:0] victim_line;
  logic [4:0]  victim_tag;
  logic [10:0] req_line;
  logic [63:0] fill_line;
  // Set for the first IDLE cycle after UPD: that lookup is the replay of the
  // request that just missed, so its hit must not be counted.
  logic        post_fill;

  logic        req;
  logic        miss;
  logic [3:0][15:0] rd_words;
  logic [3:0][15:0] wr_words;

  assign req  = cpu_re | cpu_we;
  assign miss = req & ~c_hit;

  // Store merge: resident line with the addressed word replaced.
  always_comb begin
    rd_words = c_rd_data;
    wr_words = rd_words;
    wr_words[cpu_addr[1:0]] = cpu_wdata;
  end

  assign cpu_rdata = rd_words[cpu_addr[1:0]];
  assign m_wdata   = victim_line;

  // Cache-side controls are combinational so a hit costs no cycle.
  // cpu_we wins over cpu_re if both are ever high.
  always_comb begin
    c_addr    = req_line;
    c_re      = 1'b0;
    c_we      = 1'b0;
    c_wdirty  = 1'b0;
    c_wr_data = fill_line;
    cpu_stall = 1'b1;
    case (state)
      IDLE: begin
        c_addr    = cpu_addr[12:2];
        c_re      = req;
        cpu_stall = miss;
        c_wr_data = wr_words;
        if (cpu_we & c_hit) begin
          c_we     = 1'b1;
          c_wdirty = 1'b1;
        end
      end
      UPD:     c_we = 1'b1;
      default: ;
    endcase
  end

  // Miss sequencer; memory-port controls are registered on each transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      victim_line <= '0;
      victim_tag  <= '0;
      req_line    <= '0;
      fill_line   <= '0;
      post_fill   <= 1'b0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      m_re        <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          post_fill <= 1'b0;
          if (req & c_hit & ~post_fill & (hit_cnt != '1))
            hit_cnt <= hit_cnt + CNT_ONE;
          if (miss) begin
            victim_line <= c_rd_data;
            victim_tag  <= c_tag_out;
            req_line    <= cpu_addr[12:2];
            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_ONE;
            if (c_dirty) begin
              state  <= WB;
              m_we   <= 1'b1;
              m_addr <= {c_tag_out, cpu_addr[7:2]};
            end else begin
              state  <= FILL;
              m_re   <= 1'b1;
              m_addr <= cpu_addr[12:2];
            end
          end
        end
        WB: if (m_rdy) begin
          state  <= FILL;
          m_we   <= 1'b0;
          m_re   <= 1'b1;
          m_addr <= req_line;
        end
        FILL: if (m_rdy) begin
          state     <= UPD;
          m_re      <= 1'b0;
          fill_line <= m_rdata;
        end
        UPD: begin
          state     <= IDLE;
          post_fill <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
